// File: rtl/ls374_bus_reader_pkg.sv
// Shared types and constants for the ls374 bus reader: FSM states, retry limit
// and the nominal read latency.
package ls374_rd_pkg;

  typedef enum logic [1:0] {IDLE, ENABLE, GAP, DONE} rd_state_e;

  localparam logic [1:0] RETRY_LIMIT = 2'd3;

  // Cycles from request acceptance to the first rd_valid cycle, with no retries.
  function automatic int rd_latency(input int num_latch, input int settle);
    return num_latch * (settle + 1) + 1;
  endfunction

endpackage

// File: rtl/ls374_bus_reader_if.sv
// Latch-bank bus plus consumer handshake for the ls374 bus reader.
// The master modport is the reader; slave is the latch bank / consumer side.
interface ls374_bus_reader_if #(
  parameter int LATCH_W   = 4,
  parameter int NUM_LATCH = 2
);
  logic [LATCH_W-1:0]           bus;
  logic [NUM_LATCH-1:0]         oe_n;
  logic                         rd_req;
  logic                         busy;
  logic [LATCH_W*NUM_LATCH-1:0] rd_data;
  logic                         rd_valid;
  logic                         rd_ready;
  logic                         rd_err;

  modport master (
    input  bus, rd_req, rd_ready,
    output oe_n, busy, rd_data, rd_valid, rd_err
  );

  modport slave (
    output bus, rd_req, rd_ready,
    input  oe_n, busy, rd_data, rd_valid, rd_err
  );
endinterface

// File: rtl/ls374_bus_reader_timer.sv
// Settle down-counter with per-latch retry tracking. load starts a fresh latch
// window, extend restarts the window and consumes one retry.
module ls374_rd_timer
  import ls374_rd_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic extend,
  output logic cnt_done,
  output logic retry_exh
);
  localparam int CW = $clog2(SETTLE + 1);

  logic [CW-1:0] cnt;
  logic [1:0]    retries;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      retries <= '0;
    end else if (load) begin
      cnt     <= CW'(SETTLE);
      retries <= '0;
    end else if (extend) begin
      cnt     <= CW'(SETTLE);
      retries <= retries + 2'd1;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // cnt==1 marks the last enabled cycle of the current window
  assign cnt_done  = (cnt == CW'(1));
  assign retry_exh = (retries == RETRY_LIMIT);

endmodule

// File: rtl/ls374_bus_reader.sv
// Read-side controller for a bank of ls374 latches on a shared bus.
// DOUBLE_SAMPLE_EN adds compare-and-retry sampling with a sticky rd_err.
module ls374_bus_reader
  import ls374_rd_pkg::*;
#(
  parameter int LATCH_W   = 4,
  parameter int NUM_LATCH = 2,
  parameter int SETTLE    = 2
) (
  input logic               clk,
  input logic               reset,
  ls374_bus_reader_if.master io
);
  localparam int IW = (NUM_LATCH > 1) ? $clog2(NUM_LATCH) : 1;
  localparam int DW = LATCH_W * NUM_LATCH;
  localparam logic [IW-1:0] LAST = IW'(NUM_LATCH - 1);

  rd_state_e     state;
  logic [IW-1:0] idx;
  logic [DW-1:0] asm_q;
  logic          err_acc;
  logic          accept, load, extend, capture, mismatch;
  logic          cnt_done, retry_exh;

`ifdef DOUBLE_SAMPLE_EN
  logic [LATCH_W-1:0] prev_bus;

  always_ff @(posedge clk) begin
    if (reset) prev_bus <= '0;
    else       prev_bus <= io.bus;
  end

  // SETTLE>=2 keeps both compared samples inside the enabled window
  assign mismatch = (io.bus != prev_bus);
`else
  assign mismatch = 1'b0;
`endif

  function automatic logic [NUM_LATCH-1:0] enable_n(input logic [IW-1:0] i);
    return ~(NUM_LATCH'(1) << i);
  endfunction

  always_comb begin
    accept  = (state == IDLE) && io.rd_req && !io.rd_valid;
    load    = accept || ((state == GAP) && (idx != LAST));
    extend  = (state == ENABLE) && cnt_done && mismatch && !retry_exh;
    capture = (state == ENABLE) && cnt_done && !extend;
  end

  ls374_rd_timer #(.SETTLE(SETTLE)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .extend    (extend),
    .cnt_done  (cnt_done),
    .retry_exh (retry_exh)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      asm_q       <= '0;
      err_acc     <= 1'b0;
      io.oe_n     <= '1;
      io.busy     <= 1'b0;
      io.rd_data  <= '0;
      io.rd_valid <= 1'b0;
      io.rd_err   <= 1'b0;
    end else begin
      if (io.rd_valid && io.rd_ready) io.rd_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state     <= ENABLE;
          idx       <= '0;
          err_acc   <= 1'b0;
          io.rd_err <= 1'b0;
          io.busy   <= 1'b1;
          io.oe_n   <= enable_n('0);
        end
        ENABLE: if (capture) begin
          for (int k = 0; k < NUM_LATCH; k++)
            if (idx == IW'(k)) asm_q[k*LATCH_W +: LATCH_W] <= io.bus;
          err_acc <= err_acc | mismatch;
          io.oe_n <= '1;
          state   <= GAP;
        end
        GAP: if (idx != LAST) begin
          idx     <= idx + IW'(1);
          io.oe_n <= enable_n(idx + IW'(1));
          state   <= ENABLE;
        end else begin
          io.rd_data  <= asm_q;
          io.rd_valid <= 1'b1;
          io.rd_err   <= err_acc;
          io.busy     <= 1'b0;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
